// File: rtl/hough_vote_sequencer_if.sv
// Pixel stream into, and vote stream out of, the Hough vote sequencer.
// The sequencer itself uses the master modport; the pixel source and the
// accumulator side use the slave modport.
interface hough_vote_sequencer_if;
   logic       pixel_in;
   logic       pixel_valid;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       vote_valid;
   logic       vote_ready;
   logic [9:0] vote_x;
   logic [9:0] vote_y;
   logic [7:0] vote_theta;

   // Sequencer view: consumes edge pixels, issues vote commands.
   modport master (
      input  pixel_in, pixel_valid, pixel_x, pixel_y, vote_ready,
      output vote_valid, vote_x, vote_y, vote_theta
   );

   // Environment view: supplies edge pixels, accepts vote commands.
   modport slave (
      output pixel_in, pixel_valid, pixel_x, pixel_y, vote_ready,
      input  vote_valid, vote_x, vote_y, vote_theta
   );
endinterface

// File: rtl/hough_vote_sequencer.sv
// Frame-level controller for the Hough accumulator. Buffers edge pixels in a
// small FIFO, expands each into THETA_STEPS vote commands, and sequences the
// CLEAR / IDLE / ACCUM / DRAIN / SEARCH phases so the accumulator RAM is only
// ever driven by one phase at a time.
// Optional feature: define HOUGH_SEQ_DROP_CNT_EN to add drop_count_o, a
// saturating count of edge pixels lost on a full FIFO.
module hough_vote_sequencer #(
   parameter int THETA_STEPS = 90,
   parameter int ACC_DEPTH   = 50400,
   parameter int ADDR_BITS   = 16,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   hough_vote_sequencer_if.master        bus,
   input  logic                          frame_start_i,
   input  logic                          frame_end_i,
   input  logic                          search_done_i,
   output logic                          clr_en_o,
   output logic [ADDR_BITS-1:0]          clr_addr_o,
   output logic                          search_start_o,
   output logic [2:0]                    phase_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic                          overflow_o,
   output logic                          frame_missed_o
`ifdef HOUGH_SEQ_DROP_CNT_EN
   ,
   output logic [15:0]                   drop_count_o
`endif
);

   localparam int PTR_BITS = $clog2(FIFO_DEPTH);
   localparam int CNT_BITS = PTR_BITS + 1;
   localparam logic [7:0]           THETA_LAST = 8'(THETA_STEPS - 1);
   localparam logic [ADDR_BITS-1:0] CLR_LAST   = ADDR_BITS'(ACC_DEPTH - 1);
   localparam logic [CNT_BITS-1:0]  FIFO_FULL  = CNT_BITS'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      CLEAR  = 3'd0,
      IDLE   = 3'd1,
      ACCUM  = 3'd2,
      DRAIN  = 3'd3,
      SEARCH = 3'd4
   } phase_e;

   phase_e                state_q, state_d;
   logic [19:0]           mem_q [FIFO_DEPTH];
   logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_BITS-1:0]   count_q, count_d;
   logic [7:0]            theta_q, theta_d;
   logic                  clr_en_q, clr_en_d;
   logic [ADDR_BITS-1:0]  clr_addr_q, clr_addr_d;
   logic                  vote_valid_q, vote_valid_d;
   logic [9:0]            vote_x_q, vote_x_d;
   logic [9:0]            vote_y_q, vote_y_d;
   logic                  search_start_q, search_start_d;
   logic                  busy_q, busy_d;
   logic                  overflow_q, overflow_d;
   logic                  frame_missed_q, frame_missed_d;
`ifdef HOUGH_SEQ_DROP_CNT_EN
   logic [15:0]           drop_cnt_q, drop_cnt_d;
`endif

   logic xfer, pop, push_req, push, drop;

   // Next-state: FIFO bookkeeping, theta stepping, phase sequencing and the
   // registered output values derived from the next state.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      state_d        = state_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      theta_d        = theta_q;
      clr_en_d       = clr_en_q;
      clr_addr_d     = clr_addr_q;
      vote_x_d       = vote_x_q;
      vote_y_d       = vote_y_q;
      search_start_d = 1'b0;
      overflow_d     = overflow_q;
`ifdef HOUGH_SEQ_DROP_CNT_EN
      drop_cnt_d     = drop_cnt_q;
`endif

      xfer     = vote_valid_q && bus.vote_ready;
      pop      = xfer && (theta_q == THETA_LAST);
      push_req = (state_q == ACCUM) && bus.pixel_valid && bus.pixel_in;
      // A full FIFO still takes a pixel when the head leaves in the same cycle.
      push     = push_req && ((count_q != FIFO_FULL) || pop);
      drop     = push_req && !push;

      if (xfer) theta_d = pop ? 8'd0 : theta_q + 8'd1;
      if (push) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
      count_d = count_q + CNT_BITS'(push) - CNT_BITS'(pop);

      if (drop) begin
         overflow_d = 1'b1;
`ifdef HOUGH_SEQ_DROP_CNT_EN
         if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
`endif
      end

      frame_missed_d = frame_start_i && (state_q != IDLE);

      unique case (state_q)
         CLEAR: begin
            // First CLEAR cycle after reset only arms the write strobe.
            if (!clr_en_q) begin
               clr_en_d   = 1'b1;
               clr_addr_d = '0;
            end else if (clr_addr_q == CLR_LAST) begin
               clr_en_d   = 1'b0;
               clr_addr_d = '0;
               state_d    = IDLE;
            end else begin
               clr_addr_d = clr_addr_q + ADDR_BITS'(1);
            end
         end
         IDLE: begin
            if (frame_start_i) begin
               state_d    = ACCUM;
               overflow_d = 1'b0;
`ifdef HOUGH_SEQ_DROP_CNT_EN
               drop_cnt_d = 16'd0;
`endif
            end
         end
         ACCUM: begin
            if (frame_end_i) state_d = DRAIN;
         end
         DRAIN: begin
            if (count_q == '0) begin
               state_d        = SEARCH;
               search_start_d = 1'b1;
            end
         end
         SEARCH: begin
            if (search_done_i) begin
               state_d    = CLEAR;
               clr_en_d   = 1'b1;
               clr_addr_d = '0;
            end
         end
         default: state_d = CLEAR;
      endcase

      busy_d       = (state_d != IDLE);
      vote_valid_d = (count_d != '0) && ((state_d == ACCUM) || (state_d == DRAIN));

      // Present the next head; a pixel written into the slot becoming head
      // this cycle is forwarded because the RAM write lands at the same edge.
      if (count_d != '0) begin
         if (push && (rd_ptr_d == wr_ptr_q)) begin
            vote_x_d = bus.pixel_x;
            vote_y_d = bus.pixel_y;
         end else begin
            {vote_x_d, vote_y_d} = mem_q[rd_ptr_d];
         end
      end
   end

   // Phase, FIFO pointers and all output registers, synchronously reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q        <= CLEAR;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         theta_q        <= 8'd0;
         clr_en_q       <= 1'b0;
         clr_addr_q     <= '0;
         vote_valid_q   <= 1'b0;
         vote_x_q       <= 10'd0;
         vote_y_q       <= 10'd0;
         search_start_q <= 1'b0;
         busy_q         <= 1'b1;
         overflow_q     <= 1'b0;
         frame_missed_q <= 1'b0;
`ifdef HOUGH_SEQ_DROP_CNT_EN
         drop_cnt_q     <= 16'd0;
`endif
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         theta_q        <= theta_d;
         clr_en_q       <= clr_en_d;
         clr_addr_q     <= clr_addr_d;
         vote_valid_q   <= vote_valid_d;
         vote_x_q       <= vote_x_d;
         vote_y_q       <= vote_y_d;
         search_start_q <= search_start_d;
         busy_q         <= busy_d;
         overflow_q     <= overflow_d;
         frame_missed_q <= frame_missed_d;
`ifdef HOUGH_SEQ_DROP_CNT_EN
         drop_cnt_q     <= drop_cnt_d;
`endif
      end
   end

   // Edge-pixel storage.
   always_ff @(posedge clk) begin
      // NOTE: the FIFO array is not reset; the pointers and count define which entries are valid.
      if (push) mem_q[wr_ptr_q] <= {bus.pixel_x, bus.pixel_y};
   end

   assign bus.vote_valid = vote_valid_q;
   assign bus.vote_x     = vote_x_q;
   assign bus.vote_y     = vote_y_q;
   assign bus.vote_theta = theta_q;
   assign clr_en_o       = clr_en_q;
   assign clr_addr_o     = clr_addr_q;
   assign search_start_o = search_start_q;
   assign phase_o        = state_q;
   assign busy_o         = busy_q;
   assign fifo_level_o   = count_q;
   assign overflow_o     = overflow_q;
   assign frame_missed_o = frame_missed_q;
`ifdef HOUGH_SEQ_DROP_CNT_EN
   assign drop_count_o   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_hough_vote_sequencer.sv
// Self-checking bench for hough_vote_sequencer. A frame-level reference
// model predicts phase and status outputs every cycle and queues the vote
// commands each accepted pixel must produce; a separate monitor pops that
// queue on every vote handshake.
module tb_hough_vote_sequencer;
   localparam int T   = 4;
   localparam int ACC = 8;
   localparam int AB  = 4;
   localparam int FD  = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  frame_start, frame_end, search_done;
   logic                  clr_en, search_start, busy, overflow, frame_missed;
   logic [AB-1:0]         clr_addr;
   logic [2:0]            phase;
   logic [$clog2(FD):0]   fifo_level;
`ifdef HOUGH_SEQ_DROP_CNT_EN
   logic [15:0]           drop_count;
`endif

   hough_vote_sequencer_if bus ();

   hough_vote_sequencer #(
      .THETA_STEPS(T), .ACC_DEPTH(ACC), .ADDR_BITS(AB), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus.master),
      .frame_start_i(frame_start), .frame_end_i(frame_end), .search_done_i(search_done),
      .clr_en_o(clr_en), .clr_addr_o(clr_addr), .search_start_o(search_start),
      .phase_o(phase), .busy_o(busy), .fifo_level_o(fifo_level),
      .overflow_o(overflow), .frame_missed_o(frame_missed)
`ifdef HOUGH_SEQ_DROP_CNT_EN
      , .drop_count_o(drop_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {int x; int y; int th;} vote_t;
   vote_t exp_q[$];

   // Reference model state (values visible after the most recent edge).
   int m_ph, m_cnt, m_theta, m_clr_addr, m_drops;
   bit m_clr_en, m_ovf, m_ss, m_fm;

   // Values currently driven on the inputs.
   bit d_rst, d_fs, d_fe, d_pv, d_pin, d_rdy, d_sd;
   int d_x, d_y;

   task automatic model_edge();
      bit valid, xfer, pop, push_req, acc;
      int ph0;
      if (d_rst) begin
         m_ph = 0; m_cnt = 0; m_theta = 0; m_clr_addr = 0; m_drops = 0;
         m_clr_en = 0; m_ovf = 0; m_ss = 0; m_fm = 0;
         exp_q.delete();
         return;
      end
      ph0      = m_ph;
      valid    = (m_cnt > 0) && (ph0 == 2 || ph0 == 3);
      xfer     = valid && d_rdy;
      pop      = xfer && (m_theta == T - 1);
      push_req = (ph0 == 2) && d_pv && d_pin;
      acc      = push_req && ((m_cnt < FD) || pop);
      if (xfer) m_theta = pop ? 0 : m_theta + 1;
      if (acc) for (int k = 0; k < T; k++) exp_q.push_back('{d_x, d_y, k});
      if (push_req && !acc) begin
         m_ovf = 1;
         if (m_drops < 65535) m_drops++;
      end
      m_fm = d_fs && (ph0 != 1);
      m_ss = 0;
      case (ph0)
         0: begin
            if (!m_clr_en) begin m_clr_en = 1; m_clr_addr = 0; end
            else if (m_clr_addr == ACC - 1) begin m_clr_en = 0; m_clr_addr = 0; m_ph = 1; end
            else m_clr_addr++;
         end
         1: if (d_fs) begin m_ph = 2; m_ovf = 0; m_drops = 0; end
         2: if (d_fe) m_ph = 3;
         3: if (m_cnt == 0) begin m_ph = 4; m_ss = 1; end
         4: if (d_sd) begin m_ph = 0; m_clr_en = 1; m_clr_addr = 0; end
         default: ;
      endcase
      m_cnt = m_cnt + int'(acc) - int'(pop);
   endtask

   task automatic compare_outputs();
      check("phase", phase, m_ph);
      check("busy", busy, (m_ph != 1));
      check("clr_en", clr_en, m_clr_en);
      check("clr_addr", clr_addr, m_clr_addr);
      check("vote_valid", bus.vote_valid, (m_cnt > 0) && (m_ph == 2 || m_ph == 3));
      check("fifo_level", fifo_level, m_cnt);
      check("overflow", overflow, m_ovf);
      check("search_start", search_start, m_ss);
      check("frame_missed", frame_missed, m_fm);
`ifdef HOUGH_SEQ_DROP_CNT_EN
      check("drop_count", drop_count, m_drops);
`endif
      if (d_rst) begin
         check("rst_vote_x", bus.vote_x, 0);
         check("rst_vote_y", bus.vote_y, 0);
         check("rst_vote_theta", bus.vote_theta, 0);
      end
   endtask

   // Drive one cycle of inputs (just after an edge), then advance past the
   // next edge and compare against the model.
   task automatic cycle(input bit r, input bit fs, input bit fe, input bit pv, input bit pin,
                        input int x, input int y, input bit rdy, input bit sd);
      d_rst = r; d_fs = fs; d_fe = fe; d_pv = pv; d_pin = pin;
      d_x = x; d_y = y; d_rdy = rdy; d_sd = sd;
      rst = r; frame_start = fs; frame_end = fe; search_done = sd;
      bus.pixel_valid = pv; bus.pixel_in = pin;
      bus.pixel_x = 10'(x); bus.pixel_y = 10'(y);
      bus.vote_ready = rdy;
      @(posedge clk);
      #1;
      model_edge();
      compare_outputs();
   endtask

   task automatic idle_cycles(input int n, input bit rdy);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, rdy, 0);
   endtask

   task automatic wait_phase(input int ph, input int budget, input string name);
      int n = 0;
      while (m_ph != ph && n < budget) begin
         cycle(0, 0, (m_ph == 2), 0, 0, 0, 0, 1, (m_ph == 4));
         n++;
      end
      check(name, m_ph, ph);
   endtask

   // Monitor: pops the expected-vote queue on every handshake and checks
   // that a stalled vote holds its fields.
   bit    hold_pending = 0;
   vote_t held;
   always @(negedge clk) begin
      if (rst) begin
         hold_pending = 0;
      end else begin
         if (hold_pending) begin
            check("stall_x", bus.vote_x, held.x);
            check("stall_y", bus.vote_y, held.y);
            check("stall_theta", bus.vote_theta, held.th);
         end
         if (bus.vote_valid && bus.vote_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_vote", 1, 0);
            end else begin
               vote_t e;
               e = exp_q.pop_front();
               check("vote_x", bus.vote_x, e.x);
               check("vote_y", bus.vote_y, e.y);
               check("vote_theta", bus.vote_theta, e.th);
            end
         end
         hold_pending = bus.vote_valid && !bus.vote_ready;
         held = '{int'(bus.vote_x), int'(bus.vote_y), int'(bus.vote_theta)};
      end
   end

   initial begin
      rst = 1'b1; frame_start = 0; frame_end = 0; search_done = 0;
      bus.pixel_valid = 0; bus.pixel_in = 0; bus.pixel_x = 0; bus.pixel_y = 0;
      bus.vote_ready = 0;
      #1;

      // Reset, then the initial clear sweep into IDLE.
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 1, 1, 1, 1, 0);
      wait_phase(1, 40, "first_clear_to_idle");

      // Single pixel (5,3) with vote_ready high; the pixel offered on the
      // frame_start cycle must be ignored.
      cycle(0, 1, 0, 1, 1, 7, 7, 1, 0);
      cycle(0, 0, 0, 1, 1, 5, 3, 1, 0);
      idle_cycles(6, 1);

      // Stall for three cycles mid-pixel.
      cycle(0, 0, 0, 1, 1, 9, 4, 1, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle_cycles(3, 0);
      idle_cycles(5, 1);

      // Four back-to-back pixels into a two-entry FIFO.
      cycle(0, 0, 0, 1, 1, 11, 21, 1, 0);
      cycle(0, 0, 0, 1, 1, 12, 22, 1, 0);
      cycle(0, 0, 0, 1, 1, 13, 23, 1, 0);
      cycle(0, 0, 0, 1, 1, 14, 24, 1, 0);
      check("overflow_after_burst", overflow, 1);

      // frame_end with pixels still queued, drain, then frame_start in SEARCH.
      cycle(0, 0, 1, 0, 0, 0, 0, 1, 0);
      wait_phase(4, 40, "drain_to_search");
      cycle(0, 1, 0, 0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
      wait_phase(1, 40, "search_clear_idle");

      // Reset pulse in ACCUM with a pixel in flight.
      cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 1, 33, 44, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      wait_phase(1, 40, "reset_restart_idle");

      // Randomised frames.
      for (int c = 0; c < 3000; c++) begin
         bit r, fs, fe, pv, pin, rdy, sd;
         r   = ($urandom_range(0, 999) < 2);
         fs  = (m_ph == 1) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 99) < 2);
         fe  = (m_ph == 2) ? ($urandom_range(0, 99) < 4) : ($urandom_range(0, 99) < 2);
         pv  = ($urandom_range(0, 9) < 6);
         pin = ($urandom_range(0, 1) == 1);
         rdy = ($urandom_range(0, 3) != 0);
         sd  = (m_ph == 4) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 99) < 3);
         cycle(r, fs, fe, pv, pin, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
               rdy, sd);
      end

      wait_phase(1, 500, "final_idle");
      idle_cycles(2, 1);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/hough_vote_sequencer.md
# hough_vote_sequencer

Frame-level controller for the Hough accumulator datapath. It buffers incoming binary edge pixels in a small FIFO and serialises each one into THETA_STEPS vote commands through a valid/ready handshake. It sequences the per-frame phases (vote, drain, peak search, accumulator clear) so that a single accumulator RAM is never driven by two phases at once. It sits between the Sobel/threshold output and the accumulator/peak-search engine.

## Interface
- THETA_STEPS, 90, θ bins voted per edge pixel (2..255)
- ACC_DEPTH, 50400, accumulator bins to clear ((640+480)/2 × 90)
- ADDR_BITS, 16, clear address width; must satisfy 2^ADDR_BITS ≥ ACC_DEPTH
- FIFO_DEPTH, 16, edge-pixel FIFO entries; power of two, ≥ 2
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of frame
- frame_end  in  1  one-cycle pulse after last pixel of frame
- pixel_in  in  1  1 = edge pixel
- pixel_valid  in  1  pixel_in/x/y valid this cycle
- pixel_x  in  10  pixel column
- pixel_y  in  10  pixel row
- vote_valid  out  1  vote command valid
- vote_ready  in  1  accumulator accepts vote
- vote_x  out  10  x of pixel being voted
- vote_y  out  10  y of pixel being voted
- vote_theta  out  8  θ index, 0..THETA_STEPS-1
- clr_en  out  1  write 0 to accumulator[clr_addr]
- clr_addr  out  ADDR_BITS  clear address
- search_start  out  1  one-cycle pulse that starts the peak search
- search_done  in  1  peak search finished (pulse or level)
- phase  out  3  current state: CLEAR=0, IDLE=1, ACCUM=2, DRAIN=3, SEARCH=4
- busy  out  1  phase != IDLE
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries
- overflow  out  1  sticky: edge pixel lost this frame
- frame_missed  out  1  one-cycle pulse: frame_start ignored

## Operation
- State machine:
  - CLEAR → IDLE after the final clear write.
  - IDLE → ACCUM on frame_start.
  - ACCUM → DRAIN on frame_end.
  - DRAIN → SEARCH when the FIFO is empty and no vote is pending.
  - SEARCH → CLEAR on search_done.
- Reset enters CLEAR, so the RAM is zeroed before the first frame.
- CLEAR:
  - clr_en=1 for exactly ACC_DEPTH consecutive cycles.
  - clr_addr steps 0..ACC_DEPTH-1.
  - vote_valid=0 throughout.
- ACCUM:
  - An edge pixel (pixel_valid && pixel_in) is pushed when the FIFO is not full.
  - Pushing while full drops the pixel and sets overflow.
  - Pixels arriving in any state other than ACCUM are ignored.
- Vote issue, in ACCUM and DRAIN:
  - vote_valid = FIFO non-empty; vote_x/vote_y = FIFO head; vote_theta = θ counter.
  - Transfer occurs when vote_valid && vote_ready; θ then increments.
  - A transfer with θ = THETA_STEPS-1 pops the head and resets θ to 0.
  - While vote_valid && !vote_ready, all vote outputs hold stable.
- SEARCH: search_start pulses on the entry cycle; vote_valid=0 and clr_en=0.
- frame_start outside IDLE is ignored and pulses frame_missed.
- frame_end outside ACCUM is ignored.
- frame_start and frame_end in the same cycle:
  - In IDLE: frame_start is taken and frame_end is dropped.
  - In ACCUM: frame_end is taken.
- A simultaneous push and pop leaves fifo_level unchanged. A push and a pop are both permitted when the FIFO is full.
- overflow clears on the IDLE→ACCUM transition.

## Timing
- Reset values while rst=1:
  - phase=CLEAR, busy=1.
  - clr_en=0, clr_addr=0, vote_valid=0, vote_theta=0, vote_x=0, vote_y=0.
  - search_start=0, fifo_level=0, overflow=0, frame_missed=0.
- First clr_en=1 occurs in the cycle after rst deasserts.
- IDLE is entered the cycle after clr_addr=ACC_DEPTH-1.
- Reset asserted mid-operation: the next cycle returns to reset values, the FIFO is flushed and the clear restarts from 0.
- All outputs are registered.
- Push-to-vote latency: a pixel pushed into an empty FIFO in cycle N gives vote_valid=1 in cycle N+1.
- Throughput: one vote per cycle with vote_ready=1, i.e. THETA_STEPS cycles per edge pixel.
- frame_start in cycle N gives phase=ACCUM in N+1. Pixels sampled in cycle N are not accepted.
- search_start is asserted in the first SEARCH cycle. search_done sampled in cycle M gives phase=CLEAR in M+1.

## Configuration
- HOUGH_SEQ_DROP_CNT_EN defined:
  - Adds output drop_count [15:0], which counts edge pixels dropped on a full FIFO.
  - It saturates at 0xFFFF, resets to 0, and clears on IDLE→ACCUM.
- Undefined: the port and the counter are absent; overflow is the only loss indication.

## Test plan
- Reset release, ACC_DEPTH=8 → clr_en high for exactly 8 cycles with addr 0..7, then phase=1, busy=0.
- THETA_STEPS=4, vote_ready=1, one edge pixel at (5,3) in ACCUM → four votes (5,3) with θ 0,1,2,3 on consecutive cycles, then fifo_level=0.
- vote_ready held low for 3 cycles mid-pixel → vote_x/y/θ stable, no θ skipped or repeated.
- FIFO_DEPTH=2, THETA_STEPS=4, 4 back-to-back edge pixels → 2 dropped, overflow=1, drop_count=2 (macro on), only the first 2 pixels voted.
- frame_end with 2 pixels queued → DRAIN until 2×THETA_STEPS votes done, then a single search_start pulse; search_done → CLEAR of ACC_DEPTH cycles → IDLE.
- frame_start during SEARCH → frame_missed pulse, phase stays 4; rst pulse in ACCUM → fifo_level=0, phase=0, clear restarts at addr 0.
